pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 128, width of the payload carried between stages.
REQ-002 Parameter STAGE, default 2, index of this register's upstream bit in the stall vector.
REQ-003 Parameter STALL_W, default 6, width of the stall vector; STAGE+1 <= STALL_W-1 SHALL hold (elaboration error otherwise).
REQ-004 Parameter NOP_DATA, default all-zero (DATA_W bits), payload driven for a bubble.
REQ-005 Parameter CNT_W, default 16, width of each performance counter.
REQ-006 clk  input  1  sole clock, all state updates on rising edge.
REQ-007 rst  input  1  reset; asynchronous, active-high.
REQ-008 stall  input  STALL_W  per-stage stop request, 1 = Stop.
REQ-009 flush  input  1  discard current contents, synchronous, active-high.
REQ-010 cnt_clr  input  1  synchronous clear of both counters.
REQ-011 in_data  input  DATA_W  payload from upstream stage.
REQ-012 in_valid  input  1  upstream payload is a real instruction.
REQ-013 out_data  output  DATA_W  registered payload to downstream stage.
REQ-014 out_valid  output  1  registered valid flag.
REQ-015 bubble_cnt  output  CNT_W  count of bubbles inserted by stall.
REQ-016 hold_cnt  output  CNT_W  count of cycles spent holding.

Function
REQ-017 Let up = stall[STAGE], dn = stall[STAGE+1]; per rising edge exactly one action SHALL apply, highest priority first: flush, bubble, hold, load.
REQ-018 Flush (flush=1, any stall): out_data <= NOP_DATA, out_valid <= 0; no counter increments.
REQ-019 Bubble (up=1, dn=0): out_data <= NOP_DATA, out_valid <= 0; bubble_cnt increments.
REQ-020 Hold (up=1, dn=1): out_data, out_valid unchanged; hold_cnt increments.
REQ-021 Load (up=0): if in_valid=1, out_data <= in_data, out_valid <= 1; if in_valid=0, out_data <= NOP_DATA, out_valid <= 0 (payload sanitised).
REQ-022 Load with dn=1 SHALL still load (upstream authoritative); no counter increments.
REQ-023 Latency: in_data appears on out_data exactly one clock after the edge at which up=0; no combinational path from any input to any output.
REQ-024 Counters SHALL saturate at 2^CNT_W-1 and not wrap.
REQ-025 cnt_clr=1 SHALL zero both counters at the edge; simultaneous increment is discarded (clear wins); cnt_clr does not affect out_data/out_valid.
REQ-026 Stall bits other than STAGE and STAGE+1 SHALL be ignored.
REQ-027 X-free: out_data never driven from in_data when in_valid=0.

Reset
REQ-028 On rst=1, without waiting for clk: out_data = NOP_DATA, out_valid = 0, bubble_cnt = 0, hold_cnt = 0.
REQ-029 While rst=1 all other inputs SHALL be ignored; first action evaluated at the first rising edge after rst deasserts.
REQ-030 Reset asserted mid-hold or mid-stream SHALL discard the held payload; no state survives.

Verification
REQ-031 Stream: stall=0, in_valid=1, in_data=0xA1,0xA2,0xA3 on consecutive edges -> out_data 0xA1,0xA2,0xA3 one cycle later each, out_valid=1, counters 0.
REQ-032 Bubble: out_data=0xA1 valid, then stall=6'b000100 for 2 edges -> out_data=NOP_DATA, out_valid=0, bubble_cnt=2, hold_cnt=0.
REQ-033 Hold: out_data=0xB7 valid, stall=6'b001100 for 3 edges -> out_data stays 0xB7, out_valid=1, hold_cnt=3; release stall with in_data=0xC0 -> 0xC0 next edge.
REQ-034 Flush priority: stall=6'b001100 and flush=1 with out_data=0xB7 -> out_data=NOP_DATA, out_valid=0, hold_cnt unchanged.
REQ-035 Saturation/clear (CNT_W=2): 5 bubble edges -> bubble_cnt=3; cnt_clr=1 during a 6th bubble edge -> bubble_cnt=0.
REQ-036 Async reset: assert rst between clock edges while holding 0xB7 -> outputs NOP_DATA/0 and counters 0 before next edge; in_valid=0 load afterwards -> out_data=NOP_DATA.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
// ---------------------------------------------------------------------------
// One pipeline register between two stages.
//
// On every rising edge exactly one action applies, highest priority first:
//   flush  : insert a NOP bubble. Counters are left unchanged.
//   bubble : the upstream stage stalls and downstream runs. Insert a NOP
//            and count it in bubble_cnt.
//   hold   : both stages stall. Keep the contents and count the cycle in
//            hold_cnt.
//   load   : the upstream stage runs. Take in_data, or NOP if in_valid = 0.
//            This happens even if the downstream stage is stalled, because
//            the upstream stage is authoritative.
//
// Both counters saturate at all-ones. cnt_clr clears both counters and wins
// over a simultaneous increment.
//
// Ports
//   clk        in   sole clock, rising edge
//   rst        in   asynchronous, active-high reset
//   stall      in   STALL_W per-stage stop requests (1 = stop); only
//                   stall[STAGE] (up) and stall[STAGE+1] (dn) are used
//   flush      in   synchronous discard of current contents
//   cnt_clr    in   synchronous clear of both counters
//   in_data    in   DATA_W payload from the upstream stage
//   in_valid   in   upstream payload is a real instruction
//   out_data   out  DATA_W registered payload to the downstream stage
//   out_valid  out  registered valid flag
//   bubble_cnt out  CNT_W count of bubbles inserted by stall
//   hold_cnt   out  CNT_W count of cycles spent holding
// ---------------------------------------------------------------------------
module pipe_stage_reg #(
  parameter int                DATA_W   = 128,
  parameter int                STAGE    = 2,
  parameter int                STALL_W  = 6,
  parameter logic [DATA_W-1:0] NOP_DATA = {DATA_W{1'b0}},
  parameter int                CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic               cnt_clr,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               in_valid,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_valid,
  output logic [CNT_W-1:0]   bubble_cnt,
  output logic [CNT_W-1:0]   hold_cnt
);

  // The downstream stall bit must exist inside the stall vector.
  if ((STAGE < 0) || (STAGE + 1 > STALL_W - 1)) begin : g_bad_stage
    $error("pipe_stage_reg: STAGE+1 must be <= STALL_W-1");
  end

  typedef enum logic [1:0] {
    ACT_LOAD   = 2'd0,
    ACT_HOLD   = 2'd1,
    ACT_BUBBLE = 2'd2,
    ACT_FLUSH  = 2'd3
  } action_t;

  // Saturating increment: the counter sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (v == {CNT_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + CNT_W'(1);
    end
    return r;
  endfunction

  logic              up_s;
  logic              dn_s;
  action_t           act_s;
  logic [DATA_W-1:0] data_nxt_s;
  logic              valid_nxt_s;
  logic [CNT_W-1:0]  bubble_nxt_s;
  logic [CNT_W-1:0]  hold_nxt_s;

  // Only two stall bits matter. The remaining bits are folded into this
  // signal so that ignoring them is clearly intentional.
  logic unused_stall_s;
  assign unused_stall_s = ^stall;

  // Choose the single action for this edge, in priority order.
  always_comb begin
    up_s  = stall[STAGE];
    dn_s  = stall[STAGE+1];
    act_s = ACT_LOAD;
    if (flush) begin
      act_s = ACT_FLUSH;
    end else if (up_s && !dn_s) begin
      act_s = ACT_BUBBLE;
    end else if (up_s && dn_s) begin
      act_s = ACT_HOLD;
    end else begin
      act_s = ACT_LOAD;
    end
  end

  // Compute next payload, valid flag and counter values from the action.
  always_comb begin
    data_nxt_s   = out_data;
    valid_nxt_s  = out_valid;
    bubble_nxt_s = bubble_cnt;
    hold_nxt_s   = hold_cnt;
    case (act_s)
      ACT_FLUSH: begin
        data_nxt_s  = NOP_DATA;
        valid_nxt_s = 1'b0;
      end
      ACT_BUBBLE: begin
        data_nxt_s   = NOP_DATA;
        valid_nxt_s  = 1'b0;
        bubble_nxt_s = sat_inc(bubble_cnt);
      end
      ACT_HOLD: begin
        hold_nxt_s = sat_inc(hold_cnt);
      end
      ACT_LOAD: begin
        // An invalid slot is sanitised, so in_data never leaks when it may
        // be undefined.
        if (in_valid) begin
          data_nxt_s  = in_data;
          valid_nxt_s = 1'b1;
        end else begin
          data_nxt_s  = NOP_DATA;
          valid_nxt_s = 1'b0;
        end
      end
      default: begin
        data_nxt_s  = NOP_DATA;
        valid_nxt_s = 1'b0;
      end
    endcase
    // A clear discards any increment on the same edge.
    if (cnt_clr) begin
      bubble_nxt_s = {CNT_W{1'b0}};
      hold_nxt_s   = {CNT_W{1'b0}};
    end else begin
      bubble_nxt_s = bubble_nxt_s;
      hold_nxt_s   = hold_nxt_s;
    end
  end

  // State registers; reset acts immediately and discards any held payload.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data   <= NOP_DATA;
      out_valid  <= 1'b0;
      bubble_cnt <= {CNT_W{1'b0}};
      hold_cnt   <= {CNT_W{1'b0}};
    end else begin
      out_data   <= data_nxt_s;
      out_valid  <= valid_nxt_s;
      bubble_cnt <= bubble_nxt_s;
      hold_cnt   <= hold_nxt_s;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed scenarios plus a
// randomized run checked against a behavioural model.
module tb_pipe_stage_reg;

  localparam int          DW   = 16;
  localparam int          SW   = 6;
  localparam int          CW   = 2;
  localparam int          CMAX = (1 << CW) - 1;
  localparam logic [15:0] NOP  = 16'h5A5A;

  logic          clk;
  logic          rst;
  logic [SW-1:0] stall;
  logic          flush;
  logic          cnt_clr;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic [CW-1:0] bubble_cnt;
  logic [CW-1:0] hold_cnt;

  int n_cmp;
  int n_bad;

  // Behavioural model state
  logic [DW-1:0] m_data;
  logic          m_valid;
  int            m_bub;
  int            m_hold;

  pipe_stage_reg #(
    .DATA_W(DW), .STAGE(2), .STALL_W(SW), .NOP_DATA(NOP), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
    .in_data(in_data), .in_valid(in_valid), .out_data(out_data),
    .out_valid(out_valid), .bubble_cnt(bubble_cnt), .hold_cnt(hold_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int sat(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  // Apply the behavioural rules to the inputs present at the coming edge.
  task automatic model_edge();
    bit up;
    bit dn;
    int nb;
    int nh;
    up = stall[2];
    dn = stall[3];
    nb = m_bub;
    nh = m_hold;
    if (rst) begin
      m_data = NOP; m_valid = 1'b0; m_bub = 0; m_hold = 0;
    end else begin
      if (flush) begin
        m_data = NOP; m_valid = 1'b0;
      end else if (up && !dn) begin
        m_data = NOP; m_valid = 1'b0; nb = sat(nb);
      end else if (up && dn) begin
        nh = sat(nh);
      end else begin
        m_valid = in_valid;
        m_data  = in_valid ? in_data : NOP;
      end
      if (cnt_clr) begin
        nb = 0; nh = 0;
      end
      m_bub  = nb;
      m_hold = nh;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall = '0; flush = 1'b0; cnt_clr = 1'b0; in_data = '0; in_valid = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    #2;
    n_cmp++;
    if ({out_valid, out_data, bubble_cnt, hold_cnt} !== {1'b0, NOP, 2'd0, 2'd0}) begin
      n_bad++;
      $display("FAIL reset_state: got v=%b d=%h b=%0d h=%0d, want v=0 d=%h b=0 h=0",
               out_valid, out_data, bubble_cnt, hold_cnt, NOP);
    end
    // Inputs are ignored while reset is held.
    stall = 6'b000100; flush = 1'b0; in_valid = 1'b1; in_data = 16'h1234; cnt_clr = 1'b0;
    tick();
    stall = 6'b001100;
    tick();
    stall = 6'b000000;
    tick();
    n_cmp++;
    if ({out_valid, out_data, bubble_cnt, hold_cnt} !== {1'b0, NOP, 2'd0, 2'd0}) begin
      n_bad++;
      $display("FAIL reset_ignores_inputs: got v=%b d=%h b=%0d h=%0d, want v=0 d=%h b=0 h=0",
               out_valid, out_data, bubble_cnt, hold_cnt, NOP);
    end
    rst = 1'b0;
    idle_inputs();
  endtask

  task automatic test_stream();
    logic [DW-1:0] seq [3];
    seq[0] = 16'h00A1; seq[1] = 16'h00A2; seq[2] = 16'h00A3;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = seq[i];
      tick();
      n_cmp++;
      if ({out_valid, out_data, bubble_cnt, hold_cnt} !== {1'b1, seq[i], 2'd0, 2'd0}) begin
        n_bad++;
        $display("FAIL stream[%0d]: got v=%b d=%h b=%0d h=%0d, want v=1 d=%h b=0 h=0",
                 i, out_valid, out_data, bubble_cnt, hold_cnt, seq[i]);
      end
    end
  endtask

  task automatic test_bubble();
    do_reset();
    in_valid = 1'b1; in_data = 16'h00A1;
    tick();
    stall = 6'b000100; in_data = 16'hFFFF;
    for (int i = 1; i <= 2; i++) begin
      tick();
      n_cmp++;
      if ({out_valid, out_data, bubble_cnt, hold_cnt} !== {1'b0, NOP, 2'(i), 2'd0}) begin
        n_bad++;
        $display("FAIL bubble[%0d]: got v=%b d=%h b=%0d h=%0d, want v=0 d=%h b=%0d h=0",
                 i, out_valid, out_data, bubble_cnt, hold_cnt, NOP, i);
      end
    end
    idle_inputs();
  endtask

  task automatic test_hold();
    do_reset();
    in_valid = 1'b1; in_data = 16'h00B7;
    tick();
    stall = 6'b001100; in_data = 16'h0EEE;
    for (int i = 1; i <= 3; i++) begin
      tick();
      n_cmp++;
      if ({out_valid, out_data, bubble_cnt, hold_cnt} !== {1'b1, 16'h00B7, 2'd0, 2'(i)}) begin
        n_bad++;
        $display("FAIL hold[%0d]: got v=%b d=%h b=%0d h=%0d, want v=1 d=00b7 b=0 h=%0d",
                 i, out_valid, out_data, bubble_cnt, hold_cnt, i);
      end
    end
    stall = 6'b000000; in_data = 16'h00C0;
    tick();
    n_cmp++;
    if ({out_valid, out_data, hold_cnt} !== {1'b1, 16'h00C0, 2'd3}) begin
      n_bad++;
      $display("FAIL hold_release: got v=%b d=%h h=%0d, want v=1 d=00c0 h=3",
               out_valid, out_data, hold_cnt);
    end
    // Flush wins over hold and leaves hold_cnt alone.
    in_data = 16'h00B7;
    tick();
    stall = 6'b001100; flush = 1'b1;
    tick();
    n_cmp++;
    if ({out_valid, out_data, bubble_cnt, hold_cnt} !== {1'b0, NOP, 2'd0, 2'd3}) begin
      n_bad++;
      $display("FAIL flush_priority: got v=%b d=%h b=%0d h=%0d, want v=0 d=%h b=0 h=3",
               out_valid, out_data, bubble_cnt, hold_cnt, NOP);
    end
    idle_inputs();
  endtask

  task automatic test_sat_clear();
    do_reset();
    stall = 6'b000100;
    for (int i = 1; i <= 5; i++) begin
      tick();
      n_cmp++;
      if (bubble_cnt !== 2'((i > 3) ? 3 : i)) begin
        n_bad++;
        $display("FAIL sat_bubble[%0d]: got %0d, want %0d", i, bubble_cnt, (i > 3) ? 3 : i);
      end
    end
    cnt_clr = 1'b1;
    tick();
    n_cmp++;
    if ({bubble_cnt, hold_cnt} !== {2'd0, 2'd0}) begin
      n_bad++;
      $display("FAIL clear_wins: got b=%0d h=%0d, want b=0 h=0", bubble_cnt, hold_cnt);
    end
    // Clearing does not disturb a load.
    stall = 6'b000000; in_valid = 1'b1; in_data = 16'h00D4;
    tick();
    n_cmp++;
    if ({out_valid, out_data} !== {1'b1, 16'h00D4}) begin
      n_bad++;
      $display("FAIL clear_keeps_data: got v=%b d=%h, want v=1 d=00d4", out_valid, out_data);
    end
    idle_inputs();
  endtask

  task automatic test_async_reset();
    do_reset();
    in_valid = 1'b1; in_data = 16'h00B7;
    tick();
    stall = 6'b001100;
    tick();
    rst = 1'b1;
    m_data = NOP; m_valid = 1'b0; m_bub = 0; m_hold = 0;
    #2;
    n_cmp++;
    if ({out_valid, out_data, bubble_cnt, hold_cnt} !== {1'b0, NOP, 2'd0, 2'd0}) begin
      n_bad++;
      $display("FAIL async_reset: got v=%b d=%h b=%0d h=%0d, want v=0 d=%h b=0 h=0",
               out_valid, out_data, bubble_cnt, hold_cnt, NOP);
    end
    #1;
    rst = 1'b0;
    stall = 6'b000000; in_valid = 1'b0; in_data = 16'hBEEF;
    tick();
    n_cmp++;
    if ({out_valid, out_data} !== {1'b0, NOP}) begin
      n_bad++;
      $display("FAIL sanitised_load: got v=%b d=%h, want v=0 d=%h", out_valid, out_data, NOP);
    end
    idle_inputs();
  endtask

  task automatic test_ignored_bits();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      stall    = 6'($urandom) & 6'b110011;
      in_valid = 1'b1;
      in_data  = 16'($urandom);
      tick();
      n_cmp++;
      if ({out_valid, out_data, bubble_cnt, hold_cnt} !== {1'b1, m_data, 2'd0, 2'd0}) begin
        n_bad++;
        $display("FAIL ignored_bits[%0d]: stall=%b got v=%b d=%h b=%0d h=%0d, want v=1 d=%h",
                 i, stall, out_valid, out_data, bubble_cnt, hold_cnt, m_data);
      end
    end
    idle_inputs();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 300; i++) begin
      stall    = 6'($urandom);
      flush    = ($urandom_range(0, 7) == 0);
      cnt_clr  = ($urandom_range(0, 9) == 0);
      in_valid = $urandom_range(0, 1) == 1;
      in_data  = 16'($urandom);
      tick();
      n_cmp++;
      if ({out_valid, out_data} !== {m_valid, m_data}) begin
        n_bad++;
        $display("FAIL random_data[%0d]: got v=%b d=%h, want v=%b d=%h",
                 i, out_valid, out_data, m_valid, m_data);
      end
      n_cmp++;
      if ({bubble_cnt, hold_cnt} !== {2'(m_bub), 2'(m_hold)}) begin
        n_bad++;
        $display("FAIL random_cnt[%0d]: got b=%0d h=%0d, want b=%0d h=%0d",
                 i, bubble_cnt, hold_cnt, m_bub, m_hold);
      end
    end
    idle_inputs();
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    m_data = NOP; m_valid = 1'b0; m_bub = 0; m_hold = 0;
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_stream();
    test_bubble();
    test_hold();
    test_sat_clear();
    test_async_reset();
    test_ignored_bits();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
